// File: rtl/jam_pkg.sv
// jam_pkg: shared definitions for the job-assignment solver.
// Contents: FSM state encoding, optimisation-mode constants and a factorial
//   helper for compile-time permutation counts.
package jam_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // n! for elaboration-time sizing (8! = 40320 fits easily in an int).
  function automatic int factorial(input int n);
    int f;
    f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

endpackage

// File: rtl/jam_perm_gen.sv
// jam_perm_gen: lexicographic permutation generator, one step per cycle.
// Latency: Perm updates on the edge where Init or Step is sampled high.
// Ports: CLK/RST, Init (load identity), Step (advance), Perm (packed, element
//   w at [w*IW +: IW]), Last (current permutation is the descending one).
module jam_perm_gen #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Init,
  input  logic            Step,
  output logic [N*IW-1:0] Perm,
  output logic            Last
);

  logic [IW-1:0] perm_q [N];
  logic [IW-1:0] perm_d [N];
  logic [IW-1:0] swp    [N];
  logic [IW-1:0] piv;
  logic [IW-1:0] suc;
  logic          found;

  // Classic next-permutation:
  //   pivot     = largest i with p[i] < p[i+1]
  //   successor = largest j > pivot with p[j] > p[pivot]
  //   swap them, then reverse the suffix after the pivot.
  // No pivot means the sequence is descending, i.e. the last permutation.
  always_comb begin
    found = 1'b0;
    piv   = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm_q[i] < perm_q[i+1]) begin
        found = 1'b1;
        piv   = IW'(i);
      end
    end

    suc = piv;
    for (int j = 1; j < N; j++) begin
      if ((j > int'(piv)) && (perm_q[j] > perm_q[piv])) suc = IW'(j);
    end

    swp      = perm_q;
    swp[piv] = perm_q[suc];
    swp[suc] = perm_q[piv];

    // Suffix reversal: position k (> pivot) takes element N+pivot-k.
    perm_d = swp;
    for (int k = 1; k < N; k++) begin
      if (k > int'(piv)) perm_d[k] = swp[IW'(N + int'(piv) - k)];
    end

    if (!found) perm_d = perm_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N; i++) perm_q[i] <= IW'(i);
    end else if (Init) begin
      for (int i = 0; i < N; i++) perm_q[i] <= IW'(i);
    end else if (Step) begin
      perm_q <= perm_d;
    end
  end

  always_comb begin
    Perm = '0;
    for (int w = 0; w < N; w++) Perm[w*IW +: IW] = perm_q[w];
  end

  assign Last = ~found;

endmodule

// File: rtl/jam_param.sv
// jam_param: N x N job-assignment solver; loads costs from a 1-cycle ROM,
//   scores all N! assignments and reports optimum, tie count, first optimum.
// Latency: Valid rises N*N + N! + 3 edges after the accepted Start; no
//   backpressure -- Start is only honoured in IDLE/DONE.
// Ports: CLK/RST, Start/Mode in, W/J ROM address out, Cost ROM data in,
//   Busy/Valid status, BestCost/MatchCount/BestAssign results.
module jam_param
  import jam_pkg::*;
#(
  parameter  int N   = 8,
  parameter  int CW  = 7,
  parameter  int SW  = CW + $clog2(N),
  parameter  int MCW = 16,
  localparam int IW  = $clog2(N)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic            Mode,
  output logic [IW-1:0]   W,
  output logic [IW-1:0]   J,
  input  logic [CW-1:0]   Cost,
  output logic            Busy,
  output logic            Valid,
  output logic [SW-1:0]   BestCost,
  output logic [MCW-1:0]  MatchCount,
  output logic [N*IW-1:0] BestAssign
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t          state_q;
  logic            mode_q;
  logic [IW-1:0]   w_q, j_q;
  logic            addr_vld_q;       // W/J currently carry a live ROM request
  logic            cap_vld_q;        // Cost this cycle answers last cycle's request
  logic [IW-1:0]   capw_q, capj_q;   // address that Cost belongs to
  logic            first_q;          // next EVAL cycle scores the first permutation
  logic            flush_q;
  logic            busy_q, valid_q;
  logic [SW-1:0]   bc_q;
  logic [MCW-1:0]  mc_q;
  logic [N*IW-1:0] ba_q;

  logic [CW-1:0]   cost_q [N][N];

  // Pipeline: stage 1 holds the scored permutation, stage 2 the running best.
  logic            s1_vld_q, s1_first_q;
  logic [SW-1:0]   s1_sum_q;
  logic [N*IW-1:0] s1_perm_q;
  logic [SW-1:0]   best_q;
  logic [MCW-1:0]  cnt_q;
  logic [N*IW-1:0] asg_q;

  logic [N*IW-1:0] perm;
  logic            perm_last;
  logic            start_acc;
  logic [SW-1:0]   sum_d;
  logic            better_d;

  assign start_acc = Start && ((state_q == IDLE) || (state_q == DONE));

  jam_perm_gen #(.N(N)) u_perm (
    .CLK  (CLK),
    .RST  (RST),
    .Init (start_acc),
    .Step (state_q == EVAL),
    .Perm (perm),
    .Last (perm_last)
  );

  // Cost matrix: written only by the LOAD sweep, so it needs no reset.
  always_ff @(posedge CLK) begin
    if ((state_q == LOAD) && cap_vld_q) cost_q[capw_q][capj_q] <= Cost;
  end

  always_comb begin
    sum_d = '0;
    for (int w = 0; w < N; w++) sum_d = sum_d + SW'(cost_q[w][perm[w*IW +: IW]]);
  end

  always_comb begin
    better_d = (mode_q == MODE_MAX) ? (s1_sum_q > best_q) : (s1_sum_q < best_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_perm_q  <= '0;
      best_q     <= '0;
      cnt_q      <= '0;
      asg_q      <= '0;
    end else begin
      s1_vld_q   <= (state_q == EVAL);
      s1_first_q <= (state_q == EVAL) && first_q;
      if (state_q == EVAL) begin
        s1_sum_q  <= sum_d;
        s1_perm_q <= perm;
      end
      if (s1_vld_q) begin
        if (s1_first_q || better_d) begin
          best_q <= s1_sum_q;
          cnt_q  <= MCW'(1);
          asg_q  <= s1_perm_q;
        end else if ((s1_sum_q == best_q) && (cnt_q != '1)) begin
          // Ties only bump the count; the lexicographically first optimum stays.
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      mode_q     <= MODE_MIN;
      w_q        <= '0;
      j_q        <= '0;
      addr_vld_q <= 1'b0;
      cap_vld_q  <= 1'b0;
      capw_q     <= '0;
      capj_q     <= '0;
      first_q    <= 1'b0;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      bc_q       <= '0;
      mc_q       <= '0;
      for (int w = 0; w < N; w++) ba_q[w*IW +: IW] <= IW'(w);
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            state_q    <= LOAD;
            mode_q     <= Mode;
            busy_q     <= 1'b1;
            valid_q    <= 1'b0;
            w_q        <= '0;
            j_q        <= '0;
            addr_vld_q <= 1'b1;
            cap_vld_q  <= 1'b0;
          end
        end

        LOAD: begin
          cap_vld_q <= addr_vld_q;
          capw_q    <= w_q;
          capj_q    <= j_q;
          // Sweep W fastest, J slowest; park on (N-1,N-1) after the last request.
          if (addr_vld_q) begin
            if (w_q == LAST_IDX) begin
              if (j_q == LAST_IDX) begin
                addr_vld_q <= 1'b0;
              end else begin
                w_q <= '0;
                j_q <= j_q + 1'b1;
              end
            end else begin
              w_q <= w_q + 1'b1;
            end
          end
          if (cap_vld_q && (capw_q == LAST_IDX) && (capj_q == LAST_IDX)) begin
            state_q <= EVAL;
            first_q <= 1'b1;
          end
        end

        EVAL: begin
          first_q <= 1'b0;
          if (perm_last) begin
            state_q <= FLUSH;
            flush_q <= 1'b0;
          end
        end

        FLUSH: begin
          // Cycle 1 lets stage 2 absorb the last permutation, cycle 2 publishes.
          if (flush_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            bc_q    <= best_q;
            mc_q    <= cnt_q;
            ba_q    <= asg_q;
          end else begin
            flush_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign W          = w_q;
  assign J          = j_q;
  assign Busy       = busy_q;
  assign Valid      = valid_q;
  assign BestCost   = bc_q;
  assign MatchCount = mc_q;
  assign BestAssign = ba_q;

endmodule

// File: tb/tb_jam_param.sv
// tb_jam_param: scoreboard bench for jam_param at N=3, N=4 (MCW=4) and N=8.
// Each instance has its own synchronous cost ROM; expected results are queued
// at Start and popped by a per-instance monitor on the rising edge of Valid.
module tb_jam_param;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST;
  int   edges = 0;
  always @(posedge CLK) edges <= edges + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] cost;
    logic [31:0] cnt;
    logic [31:0] asg;
    int          e0;
    int          lat;
  } exp_t;

  exp_t q3[$], q4[$], q8a[$], q8b[$];

  // ---------------- N=3 instance ----------------
  logic        st3, md3, busy3, v3;
  logic [1:0]  w3, j3;
  logic [6:0]  c3;
  logic [8:0]  bc3;
  logic [15:0] mc3;
  logic [5:0]  ba3;
  logic [6:0]  tab3 [3][3];
  always @(posedge CLK) c3 <= tab3[w3][j3];

  jam_param #(.N(3)) u3 (
    .CLK(CLK), .RST(RST), .Start(st3), .Mode(md3), .W(w3), .J(j3), .Cost(c3),
    .Busy(busy3), .Valid(v3), .BestCost(bc3), .MatchCount(mc3), .BestAssign(ba3)
  );

  // ---------------- N=4, MCW=4 instance ----------------
  logic        st4, busy4, v4;
  logic [1:0]  w4, j4;
  logic [6:0]  c4;
  logic [8:0]  bc4;
  logic [3:0]  mc4;
  logic [7:0]  ba4;
  logic [6:0]  tab4 [4][4];
  always @(posedge CLK) c4 <= tab4[w4][j4];

  jam_param #(.N(4), .MCW(4)) u4 (
    .CLK(CLK), .RST(RST), .Start(st4), .Mode(1'b0), .W(w4), .J(j4), .Cost(c4),
    .Busy(busy4), .Valid(v4), .BestCost(bc4), .MatchCount(mc4), .BestAssign(ba4)
  );

  // ---------------- two N=8 instances run side by side ----------------
  logic        st8, md8;
  logic        busy8a, v8a, busy8b, v8b;
  logic [2:0]  w8a, j8a, w8b, j8b;
  logic [6:0]  c8a, c8b;
  logic [9:0]  bc8a, bc8b;
  logic [15:0] mc8a, mc8b;
  logic [23:0] ba8a, ba8b;
  logic [6:0]  tab8a [8][8];
  logic [6:0]  tab8b [8][8];
  always @(posedge CLK) c8a <= tab8a[w8a][j8a];
  always @(posedge CLK) c8b <= tab8b[w8b][j8b];

  jam_param u8a (
    .CLK(CLK), .RST(RST), .Start(st8), .Mode(md8), .W(w8a), .J(j8a), .Cost(c8a),
    .Busy(busy8a), .Valid(v8a), .BestCost(bc8a), .MatchCount(mc8a), .BestAssign(ba8a)
  );
  jam_param u8b (
    .CLK(CLK), .RST(RST), .Start(st8), .Mode(md8), .W(w8b), .J(j8b), .Cost(c8b),
    .Busy(busy8b), .Valid(v8b), .BestCost(bc8b), .MatchCount(mc8b), .BestAssign(ba8b)
  );

  // ---------------- checking helpers ----------------
  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk(input string nm, input exp_t e,
                     input logic [31:0] gc, input logic [31:0] gn, input logic [31:0] ga);
    cmp({nm, " BestCost"},   gc, e.cost);
    cmp({nm, " MatchCount"}, gn, e.cnt);
    cmp({nm, " BestAssign"}, ga, e.asg);
    cmp({nm, " latency"},    32'(edges - e.e0), 32'(e.lat));
  endtask

  task automatic unexpected(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s unexpected Valid: got rising Valid, expected none (t=%0t)", nm, $time);
  endtask

  function automatic logic [31:0] pack8(input int p[8]);
    logic [31:0] r;
    r = '0;
    for (int w = 0; w < 8; w++) r = r | (32'(p[w]) << (3 * w));
    return r;
  endfunction

  // ---------------- monitors ----------------
  logic v3_p = 1'b0, v4_p = 1'b0, v8a_p = 1'b0, v8b_p = 1'b0;

  always @(negedge CLK) begin
    if (v3 && !v3_p) begin
      if (q3.size() == 0) unexpected("u3");
      else chk("u3", q3.pop_front(), 32'(bc3), 32'(mc3), 32'(ba3));
    end
    v3_p = v3;
  end

  always @(negedge CLK) begin
    if (v4 && !v4_p) begin
      if (q4.size() == 0) unexpected("u4");
      else chk("u4", q4.pop_front(), 32'(bc4), 32'(mc4), 32'(ba4));
    end
    v4_p = v4;
  end

  always @(negedge CLK) begin
    if (v8a && !v8a_p) begin
      if (q8a.size() == 0) unexpected("u8a");
      else chk("u8a", q8a.pop_front(), 32'(bc8a), 32'(mc8a), 32'(ba8a));
    end
    v8a_p = v8a;
  end

  always @(negedge CLK) begin
    if (v8b && !v8b_p) begin
      if (q8b.size() == 0) unexpected("u8b");
      else chk("u8b", q8b.pop_front(), 32'(bc8b), 32'(mc8b), 32'(ba8b));
    end
    v8b_p = v8b;
  end

  // ---------------- stimulus tasks (called at a negedge) ----------------
  task automatic go3(input logic mode, input logic [31:0] c, input logic [31:0] n,
                     input logic [31:0] a);
    exp_t e;
    e.cost = c; e.cnt = n; e.asg = a; e.e0 = edges + 1; e.lat = 9 + 6 + 3;
    q3.push_back(e);
    st3 = 1'b1;
    md3 = mode;
    @(negedge CLK);
    st3 = 1'b0;
  endtask

  task automatic wait_all(input int budget);
    int k;
    k = 0;
    while ((q3.size() + q4.size() + q8a.size() + q8b.size()) != 0 && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if ((q3.size() + q4.size() + q8a.size() + q8b.size()) != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: %0d results still pending after %0d cycles",
               q3.size() + q4.size() + q8a.size() + q8b.size(), budget);
      q3.delete(); q4.delete(); q8a.delete(); q8b.delete();
    end
    @(negedge CLK);
  endtask

  task automatic check_rst3(input string tag);
    cmp({tag, " W"},          32'(w3),    32'd0);
    cmp({tag, " J"},          32'(j3),    32'd0);
    cmp({tag, " Busy"},       32'(busy3), 32'd0);
    cmp({tag, " Valid"},      32'(v3),    32'd0);
    cmp({tag, " BestCost"},   32'(bc3),   32'd0);
    cmp({tag, " MatchCount"}, 32'(mc3),   32'd0);
    cmp({tag, " BestAssign"}, 32'(ba3),   32'd36);  // {2,1,0}
  endtask

  task automatic set_tab3_lin();
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 3; j++) tab3[w][j] = 7'(3 * w + j + 1);
  endtask

  task automatic set_tab3_diag();
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 3; j++) tab3[w][j] = (w == j) ? 7'd0 : 7'd5;
  endtask

  // ---------------- main sequence ----------------
  int   p8[8];
  int   id8[8];
  exp_t e8;

  initial begin
    p8 = '{3, 7, 0, 5, 1, 6, 2, 4};
    for (int i = 0; i < 8; i++) id8[i] = i;
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) begin
        tab8a[w][j] = 7'd100;
        tab8b[w][j] = (j == p8[w]) ? 7'd0 : 7'((w * 13 + j * 7) % 127 + 1);
      end
    for (int w = 0; w < 4; w++)
      for (int j = 0; j < 4; j++) tab4[w][j] = 7'd1;
    set_tab3_lin();

    RST = 1'b1; st3 = 1'b0; md3 = 1'b0; st4 = 1'b0; st8 = 1'b0; md8 = 1'b0;
    repeat (3) @(negedge CLK);
    check_rst3("reset");
    cmp("reset u8a BestAssign", 32'(ba8a), pack8(id8));
    RST = 1'b0;
    @(negedge CLK);

    // Linear costs: every assignment sums to 15; also watch the ROM sweep.
    go3(1'b0, 32'd15, 32'd6, 32'd36);
    cmp("u3 Busy in LOAD", 32'(busy3), 32'd1);
    for (int k = 0; k < 9; k++) begin
      cmp("u3 W addr", 32'(w3), 32'(k % 3));
      cmp("u3 J addr", 32'(j3), 32'(k / 3));
      @(negedge CLK);
    end
    wait_all(100);
    cmp("u3 W hold", 32'(w3), 32'd2);
    cmp("u3 J hold", 32'(j3), 32'd2);
    cmp("u3 Busy done", 32'(busy3), 32'd0);

    // Zero diagonal: minimise then maximise without reset.
    set_tab3_diag();
    go3(1'b0, 32'd0, 32'd1, 32'd36);
    wait_all(100);
    go3(1'b1, 32'd15, 32'd2, 32'd9);   // {0,2,1}: w0->1, w1->2, w2->0
    cmp("u3 old BestCost kept", 32'(bc3), 32'd0);
    cmp("u3 Valid cleared", 32'(v3), 32'd0);
    wait_all(100);

    // Start during EVAL must be ignored.
    set_tab3_lin();
    go3(1'b0, 32'd15, 32'd6, 32'd36);
    repeat (11) @(negedge CLK);
    st3 = 1'b1;
    @(negedge CLK);
    st3 = 1'b0;
    wait_all(100);

    // Reset mid-EVAL aborts; the following run completes normally.
    go3(1'b0, 32'd15, 32'd6, 32'd36);
    repeat (11) @(negedge CLK);
    RST = 1'b1;
    q3.delete();
    @(negedge CLK);
    check_rst3("mid-run reset");
    RST = 1'b0;
    @(negedge CLK);
    set_tab3_diag();
    go3(1'b1, 32'd15, 32'd2, 32'd9);
    wait_all(100);

    // N=4 with a 4-bit counter: 24 ties saturate at 15.
    e8.cost = 32'd4; e8.cnt = 32'd15; e8.asg = 32'd228; e8.e0 = edges + 1;
    e8.lat = 16 + 24 + 3;
    q4.push_back(e8);
    st4 = 1'b1;
    @(negedge CLK);
    st4 = 1'b0;
    wait_all(200);
    cmp("u4 Busy done", 32'(busy4), 32'd0);

    // N=8: flat costs and a seeded unique zero-cost optimum, in parallel.
    e8.cost = 32'd800; e8.cnt = 32'd40320; e8.asg = pack8(id8); e8.e0 = edges + 1;
    e8.lat = 64 + 40320 + 3;
    q8a.push_back(e8);
    e8.cost = 32'd0; e8.cnt = 32'd1; e8.asg = pack8(p8);
    q8b.push_back(e8);
    st8 = 1'b1;
    md8 = 1'b0;
    @(negedge CLK);
    st8 = 1'b0;
    wait_all(45000);
    cmp("u8a Busy done", 32'(busy8a), 32'd0);
    cmp("u8b Busy done", 32'(busy8b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
